// File: rtl/mips_pkg.sv
// Shared widths and write-port types for the register-file writeback slice.
package mips_pkg;
    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              en;
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wt_t;
endpackage

// File: rtl/regwb_if.sv
// Write-request bundle shared by the WB stage and the long-latency unit.
interface regwb_if;
    import mips_pkg::*;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;
    logic              ll_valid;
    logic [REG_AW-1:0] ll_addr;
    logic [DATA_W-1:0] ll_data;
    logic              ll_ready;

    modport master (
        output wb_valid, wb_addr, wb_data,
        output ll_valid, ll_addr, ll_data,
        input  wb_ready, ll_ready
    );
    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  ll_valid, ll_addr, ll_data,
        output wb_ready, ll_ready
    );
endinterface

// File: rtl/regwb_scoreboard.sv
// Pending-write bits for long-latency destinations, with lookup ports
// for both decode operands and the WB destination.
module regwb_scoreboard
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic [REG_AW-1:0] rd_a,
    input  logic [REG_AW-1:0] rd_b,
    input  logic [REG_AW-1:0] rd_w,
    output logic              hit_a,
    output logic              hit_b,
    output logic              hit_w,
    output logic              sb_err
);
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pend_nxt;
    logic                set_ok;
    logic                clr_ok;

    assign set_ok = set_en && (set_addr != REG_ZERO);
    assign clr_ok = clr_en && (clr_addr != REG_ZERO);

    // Set is applied after clear so a same-cycle collision stays pending.
    always_comb begin
        pend_nxt = pending;
        if (clr_ok)
            pend_nxt[clr_addr] = 1'b0;
        if (set_ok)
            pend_nxt[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            pending <= pend_nxt;
            if (set_ok && pending[set_addr])
                sb_err <= 1'b1;
        end
    end

    assign hit_a = (rd_a != REG_ZERO) && pending[rd_a];
    assign hit_b = (rd_b != REG_ZERO) && pending[rd_b];
    assign hit_w = (rd_w != REG_ZERO) && pending[rd_w];
endmodule

// File: rtl/regwb_arbiter.sv
// WB/LLU arbiter for the reg32 write port with RAW stall generation.
// Define REGWB_BYPASS_EN to forward the registered write to decode.
module regwb_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    regwb_if.slave            req,
    input  logic              issue_set,
    input  logic [REG_AW-1:0] issue_addr,
    input  logic [REG_AW-1:0] Rd_addr_A,
    input  logic [REG_AW-1:0] Rd_addr_B,
    input  logic [DATA_W-1:0] rf_data_A,
    input  logic [DATA_W-1:0] rf_data_B,
    output logic [DATA_W-1:0] Rd_data_A,
    output logic [DATA_W-1:0] Rd_data_B,
    output logic              stall,
    output logic              Wt_en,
    output logic [REG_AW-1:0] Wt_addr,
    output logic [DATA_W-1:0] Wt_data,
    output logic              sb_err
);
    logic [CNT_W-1:0] cnt;
    logic             hit_a, hit_b, hit_w;
    logic             ll_first, wb_cand;
    logic             wb_gnt, ll_gnt;
    wt_t              sel;
    wt_t              wt;

    regwb_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_set),
        .set_addr (issue_addr),
        .clr_en   (ll_gnt),
        .clr_addr (req.ll_addr),
        .rd_a     (Rd_addr_A),
        .rd_b     (Rd_addr_B),
        .rd_w     (req.wb_addr),
        .hit_a    (hit_a),
        .hit_b    (hit_b),
        .hit_w    (hit_w),
        .sb_err   (sb_err)
    );

    assign ll_first = cnt >= CNT_W'(STARVE_LIMIT);
    assign wb_cand  = req.wb_valid && !hit_w;

    assign req.wb_ready = !hit_w && !(req.ll_valid && ll_first);
    assign req.ll_ready = ll_first || !wb_cand;

    assign wb_gnt = req.wb_valid && req.wb_ready;
    assign ll_gnt = req.ll_valid && req.ll_ready;

    always_comb begin
        sel = '0;
        unique case (1'b1)
            ll_gnt: sel = '{en: 1'b1, addr: req.ll_addr, data: req.ll_data};
            wb_gnt: sel = '{en: 1'b1, addr: req.wb_addr, data: req.wb_data};
            default: ;
        endcase
    end

    // Writes to r0 are accepted but never reach reg32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wt <= '0;
        end else if (sel.en && sel.addr != REG_ZERO) begin
            wt <= sel;
        end else begin
            wt.en <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (ll_gnt)
            cnt <= '0;
        else if (req.ll_valid && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign Wt_en   = wt.en;
    assign Wt_addr = wt.addr;
    assign Wt_data = wt.data;

`ifdef REGWB_BYPASS_EN
    always_comb begin
        Rd_data_A = rf_data_A;
        Rd_data_B = rf_data_B;
        if (wt.en && wt.addr == Rd_addr_A && Rd_addr_A != REG_ZERO)
            Rd_data_A = wt.data;
        if (wt.en && wt.addr == Rd_addr_B && Rd_addr_B != REG_ZERO)
            Rd_data_B = wt.data;
        stall = hit_a || hit_b;
    end
`else
    logic wt_hit_a, wt_hit_b;
    assign wt_hit_a = wt.en && wt.addr == Rd_addr_A &&
                      Rd_addr_A != REG_ZERO;
    assign wt_hit_b = wt.en && wt.addr == Rd_addr_B &&
                      Rd_addr_B != REG_ZERO;
    assign Rd_data_A = rf_data_A;
    assign Rd_data_B = rf_data_B;
    assign stall = hit_a || hit_b || wt_hit_a || wt_hit_b;
`endif
endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed and randomized checks of regwb_arbiter against a register-level model.
module tb_regwb_arbiter;
    localparam int SL   = 4;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;
`ifdef REGWB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_set;
    logic [4:0]  issue_addr, Rd_addr_A, Rd_addr_B;
    logic [31:0] rf_data_A, rf_data_B, Rd_data_A, Rd_data_B;
    logic        stall, Wt_en, sb_err;
    logic [4:0]  Wt_addr;
    logic [31:0] Wt_data;

    regwb_if bus ();

    regwb_arbiter #(.STARVE_LIMIT(SL), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (bus),
        .issue_set  (issue_set),
        .issue_addr (issue_addr),
        .Rd_addr_A  (Rd_addr_A),
        .Rd_addr_B  (Rd_addr_B),
        .rf_data_A  (rf_data_A),
        .rf_data_B  (rf_data_B),
        .Rd_data_A  (Rd_data_A),
        .Rd_data_B  (Rd_data_B),
        .stall      (stall),
        .Wt_en      (Wt_en),
        .Wt_addr    (Wt_addr),
        .Wt_data    (Wt_data),
        .sb_err     (sb_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_pend [32];
    int          m_cnt;
    bit          m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_err;
    bit          last_gw, last_gl;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_cnt = 0; m_en = 0; m_addr = '0; m_data = '0; m_err = 0;
    endtask

    function automatic bit phit(input logic [4:0] a);
        return a != 0 && m_pend[a];
    endfunction

    function automatic bit whit(input logic [4:0] a);
        return a != 0 && m_en && m_addr == a;
    endfunction

    // One cycle: check outputs against the model, then advance the model.
    task automatic step(output logic o_wbr, o_llr, o_stl,
                        output logic [31:0] o_rdb);
        bit blk, llf, gw, gl, es;
        logic [31:0] ea, eb;
        logic [4:0] wa;
        #1;
        blk = phit(bus.wb_addr);
        llf = m_cnt >= SL;
        gl  = bus.ll_valid && (llf || !(bus.wb_valid && !blk));
        gw  = bus.wb_valid && !blk && !gl;
        es  = phit(Rd_addr_A) || phit(Rd_addr_B);
        if (!BYP) es = es || whit(Rd_addr_A) || whit(Rd_addr_B);
        ea = (BYP && whit(Rd_addr_A)) ? m_data : rf_data_A;
        eb = (BYP && whit(Rd_addr_B)) ? m_data : rf_data_B;
        chk("wb_grant", bus.wb_valid && bus.wb_ready, gw);
        chk("ll_grant", bus.ll_valid && bus.ll_ready, gl);
        chk("stall", stall, es);
        chk("rd_data_a", Rd_data_A, ea);
        chk("rd_data_b", Rd_data_B, eb);
        chk("wt_en", Wt_en, m_en);
        if (m_en) begin
            chk("wt_addr", Wt_addr, m_addr);
            chk("wt_data", Wt_data, m_data);
        end
        chk("sb_err", sb_err, m_err);
        o_wbr = bus.wb_ready; o_llr = bus.ll_ready;
        o_stl = stall; o_rdb = Rd_data_B;
        last_gw = gw; last_gl = gl;
        @(posedge clk);
        if (gl) m_cnt = 0;
        else if (bus.ll_valid && m_cnt < CMAX) m_cnt++;
        m_en = 0;
        if (gl || gw) begin
            wa = gl ? bus.ll_addr : bus.wb_addr;
            if (wa != 0) begin
                m_en = 1; m_addr = wa;
                m_data = gl ? bus.ll_data : bus.wb_data;
            end
        end
        if (issue_set && phit(issue_addr)) m_err = 1;
        if (gl && bus.ll_addr != 0) m_pend[bus.ll_addr] = 0;
        if (issue_set && issue_addr != 0) m_pend[issue_addr] = 1;
        @(negedge clk);
    endtask

    logic        wr, lr, st;
    logic [31:0] rb;

    initial begin
        rst = 0; issue_set = 0; issue_addr = 0;
        Rd_addr_A = 0; Rd_addr_B = 0;
        rf_data_A = 32'h1111_0000; rf_data_B = 32'h2222_0000;
        bus.wb_valid = 0; bus.wb_addr = 0; bus.wb_data = 0;
        bus.ll_valid = 0; bus.ll_addr = 0; bus.ll_data = 0;
        model_reset();
        last_gw = 0; last_gl = 0;
        repeat (2) @(negedge clk);
        chk("rst_wt_en", Wt_en, 0);
        chk("rst_wt_addr", Wt_addr, 0);
        chk("rst_wt_data", Wt_data, 0);
        chk("rst_sb_err", sb_err, 0);
        chk("rst_stall", stall, 0);
        rst = 1;
        @(negedge clk);

        bus.wb_valid = 1; bus.wb_addr = 15; bus.wb_data = 32'd1234;
        step(wr, lr, st, rb);
        chk("t1_wb_ready", wr, 1);
        bus.wb_valid = 0;
        chk("t1_wt_en", Wt_en, 1);
        chk("t1_wt_addr", Wt_addr, 15);
        chk("t1_wt_data", Wt_data, 32'd1234);
        step(wr, lr, st, rb);

        bus.ll_valid = 1; bus.ll_addr = 9; bus.ll_data = 32'h99;
        for (int k = 0; k < 5; k++) begin
            bus.wb_valid = 1; bus.wb_addr = 5'(k + 1);
            bus.wb_data = $urandom;
            step(wr, lr, st, rb);
            chk("t2_wb_ready", wr, k < 4);
            chk("t2_ll_ready", lr, k == 4);
        end
        bus.ll_valid = 0;
        step(wr, lr, st, rb);
        chk("t2_wb_held", wr, 1);
        bus.ll_valid = 1; bus.ll_addr = 10; bus.wb_addr = 6;
        step(wr, lr, st, rb);
        chk("t2_cnt_cleared", wr, 1);
        bus.wb_valid = 0;
        step(wr, lr, st, rb);
        bus.ll_valid = 0;

        issue_set = 1; issue_addr = 7;
        step(wr, lr, st, rb);
        issue_set = 0; Rd_addr_A = 7;
        step(wr, lr, st, rb);
        chk("t3_stall_a", st, 1);
        step(wr, lr, st, rb);
        chk("t3_stall_b", st, 1);
        bus.ll_valid = 1; bus.ll_addr = 7; bus.ll_data = 32'h77;
        step(wr, lr, st, rb);
        chk("t3_ll_ready", lr, 1);
        chk("t3_stall_gnt", st, 1);
        bus.ll_valid = 0;
        step(wr, lr, st, rb);
        chk("t3_stall_after", st, !BYP);
        step(wr, lr, st, rb);
        chk("t3_stall_clear", st, 0);
        Rd_addr_A = 0;

        issue_set = 1; issue_addr = 7;
        step(wr, lr, st, rb);
        issue_set = 0;
        bus.wb_valid = 1; bus.wb_addr = 7; bus.wb_data = 32'h1;
        step(wr, lr, st, rb);
        chk("t4_waw_a", wr, 0);
        step(wr, lr, st, rb);
        chk("t4_waw_b", wr, 0);
        bus.ll_valid = 1; bus.ll_addr = 7; bus.ll_data = 32'h700;
        step(wr, lr, st, rb);
        chk("t4_ll_wins", lr, 1);
        chk("t4_wb_held", wr, 0);
        bus.ll_valid = 0;
        step(wr, lr, st, rb);
        chk("t4_wb_accept", wr, 1);
        bus.wb_valid = 0;
        step(wr, lr, st, rb);

        bus.wb_valid = 1; bus.wb_addr = 0; bus.wb_data = 32'd5;
        step(wr, lr, st, rb);
        chk("t5_r0_ready", wr, 1);
        chk("t5_r0_wt_en", Wt_en, 0);
        bus.wb_valid = 0;
        issue_set = 1; issue_addr = 0;
        step(wr, lr, st, rb);
        issue_set = 0;
        step(wr, lr, st, rb);
        chk("t5_r0_stall", st, 0);
        chk("t5_r0_err", sb_err, 0);
        issue_set = 1; issue_addr = 3;
        step(wr, lr, st, rb);
        step(wr, lr, st, rb);
        issue_set = 0;
        chk("t5_sb_err", sb_err, 1);
        bus.ll_valid = 1; bus.ll_addr = 3; bus.ll_data = 32'h3;
        step(wr, lr, st, rb);
        bus.ll_valid = 0;
        step(wr, lr, st, rb);
        chk("t5_sticky", sb_err, 1);

        bus.wb_valid = 1; bus.wb_addr = 7; bus.wb_data = 32'd5678;
        step(wr, lr, st, rb);
        bus.wb_valid = 0; Rd_addr_B = 7; rf_data_B = 32'hdead;
        step(wr, lr, st, rb);
        chk("t6_stall", st, !BYP);
        chk("t6_rd_b", rb, BYP ? 32'd5678 : 32'hdead);
        Rd_addr_B = 0;

        issue_set = 1; issue_addr = 7;
        bus.wb_valid = 1; bus.wb_addr = 12; bus.wb_data = 32'hc;
        step(wr, lr, st, rb);
        issue_set = 0; bus.wb_valid = 0; Rd_addr_A = 7;
        #2 rst = 0;
        #1;
        chk("rst_mid_wt_en", Wt_en, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_err", sb_err, 0);
        model_reset();
        @(negedge clk);
        rst = 1; Rd_addr_A = 0;
        last_gw = 0; last_gl = 0;

        for (int i = 0; i < 1500; i++) begin
            if (!bus.wb_valid || last_gw) begin
                bus.wb_valid = 1'($urandom_range(0, 1));
                bus.wb_addr = 5'($urandom_range(0, 7));
                bus.wb_data = $urandom;
            end
            if (!bus.ll_valid || last_gl) begin
                bus.ll_valid = 1'($urandom_range(0, 1));
                bus.ll_addr = 5'($urandom_range(0, 7));
                bus.ll_data = $urandom;
            end
            issue_set = ($urandom_range(0, 7) == 0);
            issue_addr = 5'($urandom_range(0, 7));
            Rd_addr_A = 5'($urandom_range(0, 7));
            Rd_addr_B = 5'($urandom_range(0, 7));
            rf_data_A = $urandom;
            rf_data_B = $urandom;
            step(wr, lr, st, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
